// File: rtl/bram_slot_poller.sv
`default_nettype none
// ============================================================================
// Module      : bram_slot_poller
// Description : Polls NUM_LOC BRAM words on request. A round-robin arbiter
//               grants one slot at a time, and the poller issues a single-cycle
//               BRAM read. It waits RD_LAT cycles, captures the word into that
//               slot's slice and pulses the slot's read_done bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_slot_poller #(
    parameter int NUM_LOC   = 4,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LOC-1:0]         read_strobe,
    output logic [WORD_W*NUM_LOC-1:0]  read_data,
    output logic [NUM_LOC-1:0]         read_done,
    output logic                       bram_en,
    output logic [ADDR_W-1:0]          bram_addr,
    input  logic [WORD_W-1:0]          bram_dout,
    output logic                       busy
);

    localparam int c_IDX_W = (NUM_LOC > 1) ? $clog2(NUM_LOC) : 1;
    localparam int c_CNT_W = $clog2(RD_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RD_LAT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_LOC - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_READ = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_IDX_W-1:0]  r_ptr;
    logic [c_IDX_W-1:0]  r_grant;
    logic [c_IDX_W-1:0]  w_pick;
    logic                w_any;
    int                  w_idx;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_wait_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_slot [NUM_LOC];

    assign w_wait_last = (r_cnt == c_CNT_LAST);

    // Round-robin search: first asserted strobe at or after the priority pointer
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        w_idx  = 0;
        for (int k = 0; k < NUM_LOC; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_LOC;
            if (!w_any && read_strobe[c_IDX_W'(w_idx)]) begin
                w_any  = 1'b1;
                w_pick = c_IDX_W'(w_idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_any) w_next = c_READ;
            c_READ:  w_next = c_WAIT;
            c_WAIT:  if (w_wait_last) w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Datapath: latch grant and address, count read latency, capture returned word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            for (int i = 0; i < NUM_LOC; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_ptr   <= (w_pick == c_IDX_LAST) ? '0 : w_pick + 1'b1;
                        r_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(w_pick);
                    end
                end
                c_READ: begin
                    r_cnt <= '0;
                end
                c_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_wait_last) begin
                        r_slot[r_grant] <= bram_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the current state; address is held between reads
    always_comb begin
        bram_en   = (r_state == c_READ);
        busy      = (r_state != c_IDLE);
        bram_addr = r_addr;
        read_done = '0;
        if (r_state == c_DONE) begin
            read_done[r_grant] = 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_LOC; i++) begin : g_pack
            assign read_data[i*WORD_W +: WORD_W] = r_slot[i];
        end
    endgenerate

endmodule
`default_nettype wire
